ca_frame_source: RTL and testbench
==================================

# ca_frame_source

Synchronous stimulus source for the lock-in / coherent-average chain. It emits a periodic, frame-aligned test waveform with optional deterministic LFSR noise, N samples per period, for exactly M periods per acquisition. Each sample carries frame-start and frame-end markers. It sits upstream of the coherent averager and replaces the free-running ADC path during bring-up and regression. The averager is the consumer; this block is the producer end of the same sample/frame interface.

## Interface
- N, 8192: samples per period; power of two, ≥4.
- M, 128: periods per acquisition; ≥1.
- DATA_WIDTH, 16: signed sample width.
- WAVE, 0: waveform select. 0 = square, 1 = sawtooth.
- AMP, 1000: square amplitude; signed, fits DATA_WIDTH.
- SAW_SHIFT, 0: left shift applied to the sawtooth ramp.
- OFFSET, 0: signed DC offset added to every sample.
- NOISE_SHIFT, 16: arithmetic right shift applied to the noise; 16 disables noise.
- clk, input, 1: single clock (50 MHz).
- reset_n, input, 1: reset; asynchronous, active-low.
- enable, input, 1: permits new samples to be offered.
- start, input, 1: single-cycle pulse that begins an acquisition.
- ready_in, input, 1: consumer accepts the sample.
- data_out, output, DATA_WIDTH: signed sample.
- valid_out, output, 1: data_out and the markers are valid.
- sof, output, 1: the offered sample is index 0 of its period.
- eof, output, 1: the offered sample is index N-1 of its period.
- frame_count, output, 16: index of the current period, 0..M-1.
- busy, output, 1: high in RUN.
- done, output, 1: acquisition complete.

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE→RUN on start.
  - RUN→DONE on the accepted transfer with sample_idx = N-1 and frame_idx = M-1.
  - DONE→RUN on start, which restarts with both counters at 0 and the LFSR reseeded.
  - start is ignored in RUN.
- A transfer occurs on a cycle with valid_out && ready_in.
- Counters:
  - sample_idx advances on each transfer and wraps from N-1 to 0.
  - frame_idx advances on that wrap.
  - frame_count = frame_idx.
- Waveform at sample index p:
  - Square: +AMP for p < N/2, otherwise −AMP.
  - Sawtooth: (p − N/2) << SAW_SHIFT.
- Noise:
  - 16-bit Galois LFSR, mask 0xB400, seed 0xACE1.
  - Shift right; if the bit shifted out is 1, XOR the result with 0xB400.
  - noise = $signed(lfsr) >>> NOISE_SHIFT. It is forced to 0 when NOISE_SHIFT ≥ 16.
  - The LFSR advances only on a transfer, so the sample sequence is independent of backpressure.
- Arithmetic:
  - sum = wave + OFFSET + noise, computed at DATA_WIDTH+2 bits.
  - The sum saturates to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- sof = (sample_idx == 0) and eof = (sample_idx == N-1), qualified by valid_out.
- Handshake rules:
  - Once valid_out is high, it stays high and data_out, sof and eof stay stable until the transfer.
  - enable low only prevents a new valid_out from rising.
- done is high in DONE and stays high until start or reset.

## Timing
- All outputs are registered.
- Reset values: data_out=0, valid_out=0, sof=0, eof=0, frame_count=0, busy=0, done=0, FSM=IDLE, LFSR=0xACE1.
- Start latency: start sampled at edge t makes busy=1 after t. If enable=1, valid_out=1 with sample 0 after edge t+1.
- Throughput: one sample per cycle while ready_in=1 and enable=1. A full acquisition takes N·M cycles plus 1.
- Transfer on the final sample at edge t: valid_out=0, busy=0, done=1 after edge t.
- Pause with enable: if enable falls while valid_out=0, no sample is offered. The next sample appears the cycle after enable returns.
- Reset asserted mid-acquisition: all outputs clear immediately. Nothing is retained after reset releases, and a new start is required.

## Test plan
- Square waveform, N=8, M=2, AMP=100, noise off, ready_in=1:
  - data_out = 100,100,100,100,−100,−100,−100,−100, repeated twice.
  - sof on samples 0 and 8; eof on samples 7 and 15.
  - frame_count goes 0 then 1.
  - done is high on the cycle after the 16th transfer.
- Backpressure: toggle ready_in pseudo-randomly.
  - Every sample is held stable until accepted.
  - The sample sequence is identical to the first test.
  - Exactly N·M transfers occur.
- Noise, AMP=0, OFFSET=0, NOISE_SHIFT=0:
  - First two samples are −21279 (0xACE1) and −7568 (0xE270).
  - Restarting from DONE reproduces the same values.
- Saturation, AMP=32767, OFFSET=10, DATA_WIDTH=16:
  - First-half samples = 32767.
  - Second-half samples = −32757.
- Sawtooth, N=8, SAW_SHIFT=2: data_out = −16,−12,−8,−4,0,4,8,12 per period.
- Reset and enable:
  - Assert reset_n=0 in the middle of frame 1: all outputs are 0 immediately.
  - After release: valid_out stays 0 until start.
  - With enable=0 after start: no valid_out appears.
  - Raising enable: sample 0 follows one cycle later.

Source files
------------

// File: rtl/ca_frame_source.sv
// Frame-aligned stimulus source: N samples per period, M periods per acquisition,
// square or sawtooth wave plus optional Galois-LFSR noise, behind a valid/ready handshake.
module ca_frame_source #(
  parameter int N           = 8192,
  parameter int M           = 128,
  parameter int DATA_WIDTH  = 16,
  parameter int WAVE        = 0,
  parameter int AMP         = 1000,
  parameter int SAW_SHIFT   = 0,
  parameter int OFFSET      = 0,
  parameter int NOISE_SHIFT = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         start,
  input  logic                         ready_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         valid_out,
  output logic                         sof,
  output logic                         eof,
  output logic [15:0]                  frame_count,
  output logic                         busy,
  output logic                         done
);

  localparam int IDX_W = $clog2(N);
  localparam int SW    = DATA_WIDTH + 2;

  localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(N - 1);
  localparam logic [15:0]          LAST_FRAME = 16'(M - 1);
  localparam logic [15:0]          LFSR_SEED  = 16'hACE1;
  localparam logic [15:0]          LFSR_MASK  = 16'hB400;
  localparam logic signed [SW-1:0] AMP_S      = SW'(AMP);
  localparam logic signed [SW-1:0] NEG_AMP_S  = SW'(-AMP);
  localparam logic signed [SW-1:0] OFFSET_S   = SW'(OFFSET);
  localparam logic signed [SW-1:0] HALF_S     = SW'(N / 2);
  localparam logic signed [SW-1:0] SAT_MAX    = {3'b000, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN    = {3'b111, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        sample_idx_q, sample_idx_d;
  logic [15:0]             frame_idx_q, frame_idx_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic signed [DATA_WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    sof_q, sof_d;
  logic                    eof_q, eof_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    xfer;
  logic                    load;
  logic                    clear_out;
  logic signed [SW-1:0]    wave_s;
  logic signed [SW-1:0]    noise_s;
  logic signed [SW-1:0]    sum_s;
  logic signed [DATA_WIDTH-1:0] sat_s;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

  assign xfer = valid_q && ready_in;

  // Control: counters and LFSR already point at the sample to be offered next.
  always_comb begin
    state_d      = state_q;
    sample_idx_d = sample_idx_q;
    frame_idx_d  = frame_idx_q;
    lfsr_d       = lfsr_q;
    busy_d       = busy_q;
    done_d       = done_q;
    load         = 1'b0;
    clear_out    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RUN;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          sample_idx_d = '0;
          frame_idx_d  = '0;
          lfsr_d       = LFSR_SEED;
        end
      end
      RUN: begin
        if (xfer) begin
          clear_out = 1'b1;
          lfsr_d    = lfsr_step(lfsr_q);
          if (sample_idx_q == LAST_IDX) begin
            sample_idx_d = '0;
            if (frame_idx_q == LAST_FRAME) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              frame_idx_d = frame_idx_q + 16'd1;
            end
          end else begin
            sample_idx_d = sample_idx_q + 1'b1;
          end
          load = enable && !((sample_idx_q == LAST_IDX) && (frame_idx_q == LAST_FRAME));
        end else if (!valid_q) begin
          load = enable;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  generate
    if (WAVE == 1) begin : g_saw
      logic signed [SW-1:0] idx_s;
      assign idx_s  = $signed({{(SW-IDX_W){1'b0}}, sample_idx_d});
      assign wave_s = (idx_s - HALF_S) <<< SAW_SHIFT;
    end else begin : g_square
      // N is a power of two, so the index MSB marks the second half-period.
      assign wave_s = sample_idx_d[IDX_W-1] ? NEG_AMP_S : AMP_S;
    end

    if (NOISE_SHIFT >= 16) begin : g_no_noise
      assign noise_s = '0;
    end else begin : g_noise
      logic signed [15:0] noise16;
      assign noise16 = $signed(lfsr_d) >>> NOISE_SHIFT;
      if (SW > 16) begin : g_ext
        assign noise_s = {{(SW-16){noise16[15]}}, noise16};
      end else begin : g_trunc
        assign noise_s = noise16[SW-1:0];
      end
    end
  endgenerate

  assign sum_s = wave_s + OFFSET_S + noise_s;

  always_comb begin
    sat_s = sum_s[DATA_WIDTH-1:0];
    if (sum_s > SAT_MAX) begin
      sat_s = SAT_MAX[DATA_WIDTH-1:0];
    end else if (sum_s < SAT_MIN) begin
      sat_s = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

  // Output stage holds the offered sample until it is accepted.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    if (clear_out) begin
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
    end
    if (load) begin
      data_d  = sat_s;
      valid_d = 1'b1;
      sof_d   = (sample_idx_d == '0);
      eof_d   = (sample_idx_d == LAST_IDX);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sample_idx_q <= '0;
      frame_idx_q  <= '0;
      lfsr_q       <= LFSR_SEED;
      data_q       <= '0;
      valid_q      <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_idx_q <= sample_idx_d;
      frame_idx_q  <= frame_idx_d;
      lfsr_q       <= lfsr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign sof         = sof_q;
  assign eof         = eof_q;
  assign frame_count = frame_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ca_frame_source.sv
// Bench for ca_frame_source: four configurations (square, noise, saturation, sawtooth)
// share one set of inputs and run in lockstep against a queue of expected samples.
module tb_ca_frame_source;

  localparam int N  = 8;
  localparam int M  = 2;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic start = 1'b0;
  logic ready_in = 1'b0;

  logic signed [15:0] dout [NI];
  logic               valid_w [NI];
  logic               sof_w [NI];
  logic               eof_w [NI];
  logic [15:0]        fc_w [NI];
  logic               busy_w [NI];
  logic               done_w [NI];

  always #10 clk = ~clk;

  ca_frame_source #(.N(N), .M(M), .DATA_WIDTH(16), .WAVE(0), .AMP(100), .SAW_SHIFT(0),
                    .OFFSET(0), .NOISE_SHIFT(16)) u_sq (
    .clk(clk), .reset_n(reset_n), .enable(enable), .start(start), .ready_in(ready_in),
    .data_out(dout[0]), .valid_out(valid_w[0]), .sof(sof_w[0]), .eof(eof_w[0]),
    .frame_count(fc_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  ca_frame_source #(.N(N), .M(M), .DATA_WIDTH(16), .WAVE(0), .AMP(0), .SAW_SHIFT(0),
                    .OFFSET(0), .NOISE_SHIFT(0)) u_noise (
    .clk(clk), .reset_n(reset_n), .enable(enable), .start(start), .ready_in(ready_in),
    .data_out(dout[1]), .valid_out(valid_w[1]), .sof(sof_w[1]), .eof(eof_w[1]),
    .frame_count(fc_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  ca_frame_source #(.N(N), .M(M), .DATA_WIDTH(16), .WAVE(0), .AMP(32767), .SAW_SHIFT(0),
                    .OFFSET(10), .NOISE_SHIFT(16)) u_sat (
    .clk(clk), .reset_n(reset_n), .enable(enable), .start(start), .ready_in(ready_in),
    .data_out(dout[2]), .valid_out(valid_w[2]), .sof(sof_w[2]), .eof(eof_w[2]),
    .frame_count(fc_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  ca_frame_source #(.N(N), .M(M), .DATA_WIDTH(16), .WAVE(1), .AMP(0), .SAW_SHIFT(2),
                    .OFFSET(0), .NOISE_SHIFT(16)) u_saw (
    .clk(clk), .reset_n(reset_n), .enable(enable), .start(start), .ready_in(ready_in),
    .data_out(dout[3]), .valid_out(valid_w[3]), .sof(sof_w[3]), .eof(eof_w[3]),
    .frame_count(fc_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  typedef struct packed {
    logic [NI-1:0][15:0] d;
    logic                sof;
    logic                eof;
    logic [15:0]         frame;
  } exp_t;

  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_xfer = 0;

  logic                hold = 1'b0;
  logic [NI-1:0][15:0] hd;
  logic [NI-1:0]       hs;
  logic [NI-1:0]       he;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference sequence for one acquisition of every configuration.
  task automatic push_expected();
    logic [15:0] lfsr;
    exp_t        e;
    int          p;
    lfsr = 16'hACE1;
    for (int k = 0; k < N * M; k++) begin
      p       = k % N;
      e.d[0]  = 16'((p < N / 2) ? 100 : -100);
      e.d[1]  = lfsr;
      e.d[2]  = 16'((p < N / 2) ? 32767 : -32757);
      e.d[3]  = 16'((p - N / 2) * 4);
      e.sof   = (p == 0);
      e.eof   = (p == N - 1);
      e.frame = 16'(k / N);
      exp_q.push_back(e);
      lfsr = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    end
  endtask

  task automatic observe();
    exp_t e;
    if (hold) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("hold_valid%0d", i), valid_w[i], 1);
        check($sformatf("hold_data%0d", i), dout[i], $signed(hd[i]));
        check($sformatf("hold_sof%0d", i), sof_w[i], hs[i]);
        check($sformatf("hold_eof%0d", i), eof_w[i], he[i]);
      end
    end
    hold = 1'b0;
    if (valid_w[0] === 1'b1) begin
      if (ready_in) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          check("xfer_unexpected", n_xfer, 0);
        end else begin
          e = exp_q.pop_front();
          $display("xfer %0d: sq=%0d noise=%0d sat=%0d saw=%0d sof=%0b eof=%0b frame=%0d",
                   n_xfer, dout[0], dout[1], dout[2], dout[3], sof_w[0], eof_w[0], fc_w[0]);
          for (int i = 0; i < NI; i++) begin
            check($sformatf("valid%0d", i), valid_w[i], 1);
            check($sformatf("data%0d", i), dout[i], $signed(e.d[i]));
            check($sformatf("sof%0d", i), sof_w[i], e.sof);
            check($sformatf("eof%0d", i), eof_w[i], e.eof);
            check($sformatf("frame%0d", i), fc_w[i], e.frame);
          end
        end
      end else begin
        hold = 1'b1;
        for (int i = 0; i < NI; i++) begin
          hd[i] = dout[i];
          hs[i] = sof_w[i];
          he[i] = eof_w[i];
        end
      end
    end
  endtask

  task automatic step(input logic rdy);
    @(negedge clk);
    ready_in = rdy;
    observe();
  endtask

  task automatic start_pulse(input string name);
    @(negedge clk);
    start    = 1'b1;
    ready_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    observe();
    check({name, "_busy_after_start"}, busy_w[0], 1);
  endtask

  task automatic check_outputs_zero(input string name);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_data%0d", name, i), dout[i], 0);
      check($sformatf("%s_valid%0d", name, i), valid_w[i], 0);
      check($sformatf("%s_sof%0d", name, i), sof_w[i], 0);
      check($sformatf("%s_eof%0d", name, i), eof_w[i], 0);
      check($sformatf("%s_frame%0d", name, i), fc_w[i], 0);
      check($sformatf("%s_busy%0d", name, i), busy_w[i], 0);
      check($sformatf("%s_done%0d", name, i), done_w[i], 0);
    end
  endtask

  // Runs to the final transfer (bounded), then checks the DONE outputs.
  task automatic drain(input string name, input bit rnd, output int steps);
    steps = 0;
    while (n_xfer < N * M && steps < 400) begin
      step(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      steps++;
    end
    check({name, "_xfer_count"}, n_xfer, N * M);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_done%0d", name, i), done_w[i], 1);
      check($sformatf("%s_busy%0d", name, i), busy_w[i], 0);
      check($sformatf("%s_valid%0d", name, i), valid_w[i], 0);
    end
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int steps;

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (2) step(1'b1);
    check("idle_valid", valid_w[0], 0);

    // Acquisition 1: ready always high, full throughput
    exp_q.delete();
    push_expected();
    n_xfer = 0;
    start_pulse("acq1");
    check("acq1_valid_after_start", valid_w[0], 0);
    drain("acq1", 1'b0, steps);
    check("acq1_cycles", steps + 1, N * M + 1);

    // Acquisition 2: restart from DONE under random backpressure
    exp_q.delete();
    push_expected();
    n_xfer = 0;
    start_pulse("acq2");
    drain("acq2", 1'b1, steps);

    // Acquisition 3: reset in the middle of frame 1
    exp_q.delete();
    push_expected();
    n_xfer = 0;
    start_pulse("acq3");
    steps = 0;
    while (n_xfer < 12 && steps < 100) begin
      step(1'b1);
      steps++;
    end
    check("acq3_reached_frame1", fc_w[0], 1);
    #2 reset_n = 1'b0;
    #1 check_outputs_zero("midreset");
    hold = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      check("postreset_valid", valid_w[0], 0);
      check("postreset_busy", busy_w[0], 0);
    end

    // Start with enable low: RUN but nothing offered
    enable = 1'b0;
    push_expected();
    n_xfer = 0;
    start_pulse("acq4");
    for (int k = 0; k < 4; k++) begin
      step(1'b1);
      check("enable_low_valid", valid_w[0], 0);
    end
    enable = 1'b1;
    @(negedge clk);
    check("enable_rise_valid", valid_w[0], 1);
    observe();
    drain("acq4", 1'b0, steps);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
